// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller for an 8-stage pipelined divider: tracks in-flight ops,
// applies RISC-V divide-by-zero and signed-overflow results, and handles backpressure and flush.
module div_issue_ctrl #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             div_stall,
  output logic             div_signed,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [DEPTH-1:0] vld, is_rem, dz, ovf;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [31:0]      dvd [DEPTH];

  logic accept, new_dz, new_ovf;

  assign div_signed   = ~in_op[0];
  assign div_dividend = in_a;
  assign div_divisor  = in_b;

  assign out_valid = vld[DEPTH-1];
  assign busy      = |vld;
  assign div_stall = out_valid & ~out_ready & ~flush;
  assign in_ready  = ~div_stall & ~flush;
  assign accept    = in_valid & in_ready;

  // Special cases are flagged at issue so the divider's raw output is never trusted for them.
  assign new_dz  = (in_b == 32'd0);
  assign new_ovf = ~in_op[0] & (in_a == 32'h8000_0000) & (in_b == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      is_rem <= '0;
      dz     <= '0;
      ovf    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag[k] <= '0;
        dvd[k] <= '0;
      end
    end else if (!div_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld[k]    <= vld[k-1] & ~flush;
        is_rem[k] <= is_rem[k-1];
        dz[k]     <= dz[k-1];
        ovf[k]    <= ovf[k-1];
        tag[k]    <= tag[k-1];
        dvd[k]    <= dvd[k-1];
      end
      vld[0]    <= accept;
      is_rem[0] <= in_op[1];
      dz[0]     <= new_dz;
      ovf[0]    <= new_ovf;
      tag[0]    <= in_tag;
      dvd[0]    <= in_a;
    end
  end

  always_comb begin
    out_result = 32'd0;
    out_tag    = '0;
    if (out_valid) begin
      out_tag = tag[DEPTH-1];
      if (dz[DEPTH-1])
        out_result = is_rem[DEPTH-1] ? dvd[DEPTH-1] : 32'hFFFF_FFFF;
      else if (ovf[DEPTH-1])
        out_result = is_rem[DEPTH-1] ? 32'd0 : 32'h8000_0000;
      else
        out_result = is_rem[DEPTH-1] ? div_remainder : div_quotient;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 8-stage divider that honours div_stall.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        div_stall, div_signed;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  div_issue_ctrl #(.TAG_W(5), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .div_stall(div_stall), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider model; zero-divisor and overflow slots return junk the DUT must override.
  logic [31:0] dq [8];
  logic [31:0] dr [8];
  logic [31:0] q_in, r_in;

  always_comb begin
    q_in = 32'h1234_5678;
    r_in = 32'h9ABC_DEF0;
    if (div_divisor != 32'd0) begin
      if (!div_signed) begin
        q_in = div_dividend / div_divisor;
        r_in = div_dividend % div_divisor;
      end else if (!(div_dividend == 32'h8000_0000 && div_divisor == 32'hFFFF_FFFF)) begin
        q_in = $signed(div_dividend) / $signed(div_divisor);
        r_in = $signed(div_dividend) % $signed(div_divisor);
      end
    end
  end

  always @(posedge clk) begin
    if (!div_stall) begin
      for (int k = 7; k > 0; k--) begin
        dq[k] <= dq[k-1];
        dr[k] <= dr[k-1];
      end
      dq[0] <= q_in;
      dr[0] <= r_in;
    end
  end

  assign div_quotient  = dq[7];
  assign div_remainder = dr[7];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  logic [1:0]  v_op  [8];
  logic [31:0] v_a   [8];
  logic [31:0] v_b   [8];
  logic [31:0] v_exp [8];
  logic [31:0] bp_exp [8];
  int n_seen;

  initial begin
    v_op[0] = 2'b00; v_a[0] = 32'hFFFF_FFF9; v_b[0] = 32'd2;          v_exp[0] = 32'hFFFF_FFFD;
    v_op[1] = 2'b10; v_a[1] = 32'hFFFF_FFF9; v_b[1] = 32'd2;          v_exp[1] = 32'hFFFF_FFFF;
    v_op[2] = 2'b00; v_a[2] = 32'hFFFF_FFF9; v_b[2] = 32'd0;          v_exp[2] = 32'hFFFF_FFFF;
    v_op[3] = 2'b10; v_a[3] = 32'hFFFF_FFF9; v_b[3] = 32'd0;          v_exp[3] = 32'hFFFF_FFF9;
    v_op[4] = 2'b00; v_a[4] = 32'h8000_0000; v_b[4] = 32'hFFFF_FFFF;  v_exp[4] = 32'h8000_0000;
    v_op[5] = 2'b10; v_a[5] = 32'h8000_0000; v_b[5] = 32'hFFFF_FFFF;  v_exp[5] = 32'h0000_0000;
    v_op[6] = 2'b01; v_a[6] = 32'h8000_0000; v_b[6] = 32'hFFFF_FFFF;  v_exp[6] = 32'h0000_0000;
    v_op[7] = 2'b11; v_a[7] = 32'h8000_0000; v_b[7] = 32'd0;          v_exp[7] = 32'h8000_0000;
    // (100+i)/3 for i = 0..7
    bp_exp[0] = 32'd33; bp_exp[1] = 32'd33; bp_exp[2] = 32'd34; bp_exp[3] = 32'd34;
    bp_exp[4] = 32'd34; bp_exp[5] = 32'd35; bp_exp[6] = 32'd35; bp_exp[7] = 32'd35;

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_stall", 32'(div_stall), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // divu / remu 100/7 back to back
    drive(2'b01, 32'd100, 32'd7, 5'd3);
    #1;
    chk("pass_signed", 32'(div_signed), 32'd0);
    chk("pass_dividend", div_dividend, 32'd100);
    chk("pass_divisor", div_divisor, 32'd7);
    tick();
    drive(2'b11, 32'd100, 32'd7, 5'd4);
    tick();
    in_valid = 1'b0;
    in_op    = 2'b00;
    #1;
    chk("pass_signed_div", 32'(div_signed), 32'd1);
    ticks(5);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("divu_valid", 32'(out_valid), 32'd1);
    chk("divu_result", out_result, 32'd14);
    chk("divu_tag", 32'(out_tag), 32'd3);
    tick();
    chk("remu_result", out_result, 32'd2);
    chk("remu_tag", 32'(out_tag), 32'd4);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_result", out_result, 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // signed and special cases
    for (int i = 0; i < 8; i++) begin
      drive(v_op[i], v_a[i], v_b[i], 5'(16 + i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("spec_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("spec_result_%0d", i), out_result, v_exp[i]);
      chk($sformatf("spec_tag_%0d", i), 32'(out_tag), 32'(16 + i));
      tick();
    end
    chk("spec_drained", 32'(out_valid), 32'd0);

    // backpressure
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 32'(100 + i), 32'd3, 5'(i + 1));
      #1;
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_stall", 32'(div_stall), 32'd1);
    chk("bp_first", out_result, bp_exp[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_result_%0d", i), out_result, bp_exp[0]);
      chk($sformatf("bp_hold_tag_%0d", i), 32'(out_tag), 32'd1);
    end
    out_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        if (n_seen < 8) begin
          chk($sformatf("bp_result_%0d", n_seen), out_result, bp_exp[n_seen]);
          chk($sformatf("bp_tag_%0d", n_seen), 32'(out_tag), 32'(n_seen + 1));
        end
        n_seen++;
      end
      tick();
    end
    chk("bp_count", 32'(n_seen), 32'd8);

    // flush with a concurrent op offer
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 32'd1, 32'd1, 5'(i));
      tick();
    end
    drive(2'b01, 32'd9, 32'd1, 5'd9);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("flush_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("flush_valid_%0d", i), 32'(out_valid), 32'd0);
      tick();
    end

    // flush overrides a stalled output
    drive(2'b01, 32'd8, 32'd2, 5'd5);
    tick();
    in_valid = 1'b0;
    ticks(7);
    chk("fs_valid", 32'(out_valid), 32'd1);
    chk("fs_result", out_result, 32'd4);
    out_ready = 1'b0;
    #1;
    chk("fs_stall_on", 32'(div_stall), 32'd1);
    flush = 1'b1;
    #1;
    chk("fs_stall_off", 32'(div_stall), 32'd0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    chk("fs_valid_gone", 32'(out_valid), 32'd0);
    chk("fs_busy_gone", 32'(busy), 32'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 32'd20, 32'd4, 5'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("ar_valid_before", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_result", out_result, 32'd0);
    tick();
    rst = 1'b0;
    drive(2'b01, 32'd50, 32'd5, 5'd7);
    tick();
    in_valid = 1'b0;
    ticks(6);
    chk("ar_lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("ar_new_valid", 32'(out_valid), 32'd1);
    chk("ar_new_result", out_result, 32'd10);
    chk("ar_new_tag", 32'(out_tag), 32'd7);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
